// File: rtl/debounce_edge.sv
// debounce_edge: per-channel contact-bounce filter with registered press/release pulses
module debounce_edge #(
   parameter int WIDTH         = 1,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             any_change
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]            level_q, level_d;
   logic [WIDTH-1:0]            rise_q, rise_d;
   logic [WIDTH-1:0]            fall_q, fall_d;
   logic                        any_q, any_d;
   // count consecutive differing ticks; a matching sample cancels, the last one accepts the new level
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (tick) begin
            if (sync_in[i] == level_q[i]) cnt_d[i] = '0;
            else if (cnt_q[i] == LAST) begin
               level_d[i] = sync_in[i];
               cnt_d[i]   = '0;
               rise_d[i]  = sync_in[i];
               fall_d[i]  = ~sync_in[i];
            end
            else cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      any_d = |(rise_d | fall_d);
   end
   // state and pulse registers; reset discards any count in progress without pulsing
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         any_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         any_q   <= any_d;
      end
   end
   assign level      = level_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign any_change = any_q;
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: scoreboard plus scenario checks for three debounce_edge configurations
module tb_debounce_edge;
   typedef struct packed {
      logic [3:0]      lvl;
      logic [3:0]      rs;
      logic [3:0]      fl;
      logic            any;
      logic [3:0][7:0] cnt;
   } ms_t;
   typedef struct packed {
      ms_t a;
      ms_t b;
      ms_t c;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tick_a = 1'b1, tick_b = 1'b1, tick_c = 1'b1;
   logic [3:0] in_a = '0;
   logic [0:0] in_b = '0, in_c = '0;
   logic [3:0] level_a, rise_a, fall_a;
   logic [0:0] level_b, rise_b, fall_b, level_c, rise_c, fall_c;
   logic any_a, any_b, any_c;
   int vectors = 0;
   int miscompares = 0;
   string cur = "init";
   exp_t sb[$];
   ms_t ma = '0, mb = '0, mc = '0;
   always #5 clk = ~clk;
   debounce_edge #(.WIDTH(4), .STABLE_CYCLES(4)) dut_a (
      .clk(clk), .reset(reset), .tick(tick_a), .sync_in(in_a),
      .level(level_a), .rise(rise_a), .fall(fall_a), .any_change(any_a));
   debounce_edge #(.WIDTH(1), .STABLE_CYCLES(3)) dut_b (
      .clk(clk), .reset(reset), .tick(tick_b), .sync_in(in_b),
      .level(level_b), .rise(rise_b), .fall(fall_b), .any_change(any_b));
   debounce_edge #(.WIDTH(1), .STABLE_CYCLES(1)) dut_c (
      .clk(clk), .reset(reset), .tick(tick_c), .sync_in(in_c),
      .level(level_c), .rise(rise_c), .fall(fall_c), .any_change(any_c));
   function automatic ms_t mstep(input ms_t s, input logic r, input logic tk,
                                 input logic [3:0] in, input int w, input int stable);
      ms_t n = s;
      n.rs = '0;
      n.fl = '0;
      if (r) return '0;
      for (int i = 0; i < w; i++) begin
         if (tk) begin
            if (in[i] == s.lvl[i]) n.cnt[i] = '0;
            else if (int'(s.cnt[i]) + 1 >= stable) begin
               n.lvl[i] = in[i];
               n.cnt[i] = '0;
               if (in[i]) n.rs[i] = 1'b1;
               else n.fl[i] = 1'b1;
            end
            else n.cnt[i] = 8'(int'(s.cnt[i]) + 1);
         end
      end
      n.any = |{n.rs, n.fl};
      return n;
   endfunction
   task automatic cyc(input logic r, input logic ta, input logic [3:0] ia,
                      input logic tb_i, input logic ib, input logic tc, input logic ic);
      exp_t e;
      @(negedge clk);
      reset = r; tick_a = ta; in_a = ia; tick_b = tb_i; in_b = ib; tick_c = tc; in_c = ic;
      ma = mstep(ma, r, ta, ia, 4, 4);
      mb = mstep(mb, r, tb_i, {3'b0, ib}, 1, 3);
      mc = mstep(mc, r, tc, {3'b0, ic}, 1, 1);
      e.a = ma; e.b = mb; e.c = mc;
      sb.push_back(e);
   endtask
   task automatic cyc_a(input logic r, input logic [3:0] ia);
      cyc(r, 1'b1, ia, 1'b1, 1'b0, 1'b1, 1'b0);
   endtask
   task automatic cyc_b(input logic r, input logic t, input logic ib);
      cyc(r, 1'b1, 4'b0, t, ib, 1'b1, 1'b0);
   endtask
   task automatic cyc_c(input logic r, input logic ic);
      cyc(r, 1'b1, 4'b0, 1'b1, 1'b0, 1'b1, ic);
   endtask
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         if ({level_a, rise_a, fall_a, any_a} !== {e.a.lvl, e.a.rs, e.a.fl, e.a.any}) begin
            miscompares++;
            $display("FAIL sb_a [%s] got lvl=%b rise=%b fall=%b any=%b exp lvl=%b rise=%b fall=%b any=%b",
                     cur, level_a, rise_a, fall_a, any_a, e.a.lvl, e.a.rs, e.a.fl, e.a.any);
         end
         vectors++;
         if ({level_b, rise_b, fall_b, any_b} !== {e.b.lvl[0], e.b.rs[0], e.b.fl[0], e.b.any}) begin
            miscompares++;
            $display("FAIL sb_b [%s] got lvl=%b rise=%b fall=%b any=%b exp lvl=%b rise=%b fall=%b any=%b",
                     cur, level_b, rise_b, fall_b, any_b, e.b.lvl[0], e.b.rs[0], e.b.fl[0], e.b.any);
         end
         vectors++;
         if ({level_c, rise_c, fall_c, any_c} !== {e.c.lvl[0], e.c.rs[0], e.c.fl[0], e.c.any}) begin
            miscompares++;
            $display("FAIL sb_c [%s] got lvl=%b rise=%b fall=%b any=%b exp lvl=%b rise=%b fall=%b any=%b",
                     cur, level_c, rise_c, fall_c, any_c, e.c.lvl[0], e.c.rs[0], e.c.fl[0], e.c.any);
         end
      end
   end
   task automatic test_reset;
      cur = "reset";
      cyc_a(1'b1, 4'b0);
      cyc_a(1'b1, 4'b0);
      vectors++;
      if ({level_a, rise_a, fall_a, any_a, level_b, rise_b, level_c, rise_c} !== 17'b0) begin
         miscompares++;
         $display("FAIL reset_state got %b required 0", {level_a, rise_a, fall_a, any_a, level_b, rise_b, level_c, rise_c});
      end
   endtask
   task automatic test_clean_press;
      logic el, er;
      cur = "clean_press";
      repeat (2) cyc_a(1'b0, 4'b0);
      for (int j = 1; j <= 7; j++) begin
         cyc_a(1'b0, 4'b0001);
         if (j >= 2) begin
            el = (j - 1 >= 4);
            er = (j - 1 == 4);
            vectors++;
            if (level_a[0] !== el || rise_a[0] !== er || fall_a[0] !== 1'b0 || any_a !== er) begin
               miscompares++;
               $display("FAIL clean_press sample %0d got lvl=%b rise=%b fall=%b any=%b required lvl=%b rise=%b fall=0 any=%b",
                        j - 1, level_a[0], rise_a[0], fall_a[0], any_a, el, er, er);
            end
         end
      end
   endtask
   task automatic test_bounce;
      int bp[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
      int rp[6] = '{0, 1, 0, 0, 0, 0};
      int nr = 0, nf = 0, fr = -1, ff = -1, v;
      cur = "bounce";
      cyc_a(1'b1, 4'b0);
      cyc_a(1'b0, 4'b0);
      for (int j = 0; j < 10; j++) begin
         v = (j < 8) ? bp[j] : 1;
         cyc_a(1'b0, {3'b0, v[0]});
         if (j >= 1 && rise_a[0]) begin
            nr++;
            if (fr < 0) fr = j;
         end
      end
      vectors++;
      if (nr != 1 || fr != 8) begin
         miscompares++;
         $display("FAIL bounce_press got %0d rises first after sample %0d required 1 after sample 8", nr, fr);
      end
      for (int j = 0; j < 8; j++) begin
         v = (j < 6) ? rp[j] : 0;
         cyc_a(1'b0, {3'b0, v[0]});
         if (j >= 1 && fall_a[0]) begin
            nf++;
            if (ff < 0) ff = j;
         end
      end
      vectors++;
      if (nf != 1 || ff != 6) begin
         miscompares++;
         $display("FAIL bounce_release got %0d falls first after sample %0d required 1 after sample 6", nf, ff);
      end
   endtask
   task automatic test_tick_gating;
      logic t;
      cur = "tick_gating";
      for (int p = 0; p < 2; p++) begin
         cyc_b(1'b1, 1'b1, 1'b0);
         for (int c = 1; c <= 11; c++) begin
            t = (c % 3 == 0);
            cyc_b(1'b0, t, (p == 0) ? 1'b1 : t);
            if (c >= 9) begin
               vectors++;
               if (level_b !== (c >= 10 ? 1'b1 : 1'b0) || rise_b !== (c == 10 ? 1'b1 : 1'b0)) begin
                  miscompares++;
                  $display("FAIL tick_gating pass %0d after edge %0d got lvl=%b rise=%b required lvl=%b rise=%b",
                           p, c - 1, level_b, rise_b, c >= 10, c == 10);
               end
            end
         end
      end
   endtask
   task automatic test_multi;
      int nr = 0, na = 0, bad = 0;
      cur = "multi";
      cyc_a(1'b1, 4'b0);
      for (int j = 0; j < 10; j++) begin
         cyc_a(1'b0, {1'b0, 1'b1, (j % 2 == 0), 1'b1});
         if (j >= 1) begin
            if (rise_a == 4'b0101) nr++;
            else if (rise_a != 4'b0000) bad++;
            if (any_a) na++;
            if (level_a[1]) bad++;
         end
      end
      vectors++;
      if (nr != 1 || na != 1 || bad != 0 || level_a !== 4'b0101) begin
         miscompares++;
         $display("FAIL multi got rises=%0d any=%0d bad=%0d lvl=%b required 1 1 0 0101", nr, na, bad, level_a);
      end
   endtask
   task automatic test_reset_mid;
      int fr = -1;
      cur = "reset_mid";
      cyc_a(1'b1, 4'b0);
      cyc_a(1'b0, 4'b1);
      cyc_a(1'b0, 4'b1);
      cyc_a(1'b1, 4'b1);
      for (int j = 0; j < 6; j++) begin
         cyc_a(1'b0, 4'b1);
         if (j == 0) begin
            vectors++;
            if (level_a[0] !== 1'b0 || rise_a[0] !== 1'b0 || any_a !== 1'b0) begin
               miscompares++;
               $display("FAIL reset_mid_clear got lvl=%b rise=%b any=%b required 0 0 0", level_a[0], rise_a[0], any_a);
            end
         end
         else if (rise_a[0] && fr < 0) fr = j;
      end
      vectors++;
      if (fr != 4) begin
         miscompares++;
         $display("FAIL reset_mid_fresh got rise after sample %0d required 4", fr);
      end
      cyc_a(1'b1, 4'b1);
      cyc_a(1'b0, 4'b0);
      vectors++;
      if (level_a !== 4'b0 || fall_a !== 4'b0 || any_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_high got lvl=%b fall=%b any=%b required 0000 0000 0", level_a, fall_a, any_a);
      end
   endtask
   task automatic test_stable1;
      logic prev = 1'b0, v;
      cur = "stable1";
      cyc_c(1'b1, 1'b0);
      for (int j = 0; j < 8; j++) begin
         v = (j % 2 == 0);
         cyc_c(1'b0, v);
         if (j >= 1) begin
            vectors++;
            if (level_c !== prev || rise_c !== prev || fall_c !== ~prev || any_c !== 1'b1) begin
               miscompares++;
               $display("FAIL stable1 step %0d got lvl=%b rise=%b fall=%b any=%b required lvl=%b rise=%b fall=%b any=1",
                        j, level_c, rise_c, fall_c, any_c, prev, prev, ~prev);
            end
         end
         prev = v;
      end
   endtask
   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_tick_gating;
      test_multi;
      test_reset_mid;
      test_stable1;
      cur = "drain";
      repeat (2) begin
         @(posedge clk);
         #3;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain got %0d pending required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
